// File: rtl/write_bus_arbiter_pkg.sv
// Shared constants and the round-robin scan helper for write_bus_arbiter.
package write_bus_pkg;

  localparam int GAP_W   = 8;
  localparam int STAT_W  = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;
  localparam int MAX_REQ = 16;

  // First set bit of pending scanning ptr+1, ptr+2, ... with explicit wrap,
  // so non-power-of-2 requester counts never land on a phantom index.
  function automatic int rr_next(input int num_req, input int ptr,
                                 input logic [MAX_REQ-1:0] pending);
    int idx;
    logic found;
    rr_next = ptr;
    idx     = ptr;
    found   = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < num_req) begin
        idx = (idx == num_req - 1) ? 0 : idx + 1;
        if (!found && pending[idx]) begin
          rr_next = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/write_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: winner is the first pending slot after ptr.
module rr_pick
  import write_bus_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   winner
);

  logic [MAX_REQ-1:0] pend_ext;

  always_comb begin
    pend_ext                = '0;
    pend_ext[NUM_REQ-1:0]   = pending;
  end

  assign any    = |pending;
  assign winner = IDX_W'(rr_next(NUM_REQ, int'(ptr), pend_ext));

endmodule

// File: rtl/write_bus_arbiter.sv
// Round-robin arbiter draining one-deep per-requester slots onto a shared write bus.
// Optional grant counters when WRITE_BUS_ARB_STATS_EN is defined.
module write_bus_arbiter
  import write_bus_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WORD_WIDTH  = 8,
  parameter int VALUE_WORDS = 4,
  parameter int GAP_CYCLES  = 0,
  localparam int DATA_W     = VALUE_WORDS * WORD_WIDTH,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          i_reset_n,
  input  logic [NUM_REQ-1:0]            i_valid,
  output logic [NUM_REQ-1:0]            o_ready,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] i_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     i_data,
  output logic [WORD_WIDTH-1:0]         o_w_addr,
  output logic [DATA_W-1:0]             o_w_data,
  output logic                          o_w_en,
  output logic [IDX_W-1:0]              o_grant_id
`ifdef WRITE_BUS_ARB_STATS_EN
  ,
  input  logic                          i_stats_clr,
  output logic [NUM_REQ*STAT_W-1:0]     o_grant_count
`endif
);

  typedef struct packed {
    logic [WORD_WIDTH-1:0] addr;
    logic [DATA_W-1:0]     data;
  } slot_t;

  slot_t [NUM_REQ-1:0] slot_q;
  logic  [NUM_REQ-1:0] pend_q;
  logic  [IDX_W-1:0]   ptr_q;
  logic  [IDX_W-1:0]   winner;
  logic  [GAP_W-1:0]   gap_q;
  logic                any;
  logic                grant;

  assign grant   = any && (gap_q == '0);
  assign o_ready = ~pend_q;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .pending (pend_q),
    .ptr     (ptr_q),
    .any     (any),
    .winner  (winner)
  );

  // A slot is only granted while full, so grant-clear and refill never collide.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slot
    logic  pend;
    slot_t slot;

    always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        pend <= 1'b0;
        slot <= '0;
      end else if (grant && winner == IDX_W'(k)) begin
        pend <= 1'b0;
      end else if (i_valid[k] && !pend) begin
        pend      <= 1'b1;
        slot.addr <= i_addr[k*WORD_WIDTH +: WORD_WIDTH];
        slot.data <= i_data[k*DATA_W +: DATA_W];
      end
    end

    assign pend_q[k] = pend;
    assign slot_q[k] = slot;
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_w_en     <= 1'b0;
      o_w_addr   <= '0;
      o_w_data   <= '0;
      o_grant_id <= '0;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      gap_q      <= '0;
    end else begin
      o_w_en <= grant;
      if (grant) begin
        o_w_addr   <= slot_q[winner].addr;
        o_w_data   <= slot_q[winner].data;
        o_grant_id <= winner;
        ptr_q      <= winner;
        gap_q      <= GAP_W'(GAP_CYCLES);
      end else if (gap_q != '0) begin
        gap_q <= gap_q - 1'b1;
      end
    end
  end

`ifdef WRITE_BUS_ARB_STATS_EN
  // Clear beats a coincident grant; counters stick at STAT_MAX.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_stat
    logic [STAT_W-1:0] cnt;

    always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n)
        cnt <= '0;
      else if (i_stats_clr)
        cnt <= '0;
      else if (grant && winner == IDX_W'(k) && cnt != STAT_MAX)
        cnt <= cnt + 1'b1;
    end

    assign o_grant_count[k*STAT_W +: STAT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_write_bus_arbiter.sv
// Self-checking bench for write_bus_arbiter: directed scenarios plus a randomized
// run against a queue-free behavioural model of the arbitration rules.
module tb_write_bus_arbiter;

  localparam int N  = 4;
  localparam int WW = 8;
  localparam int VW = 4;
  localparam int DW = VW * WW;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    valid = '0;
  logic [N*WW-1:0] addr = '0;
  logic [N*DW-1:0] data = '0;

  logic [N-1:0]  ready, ready_g;
  logic [WW-1:0] w_addr, w_addr_g;
  logic [DW-1:0] w_data, w_data_g;
  logic          w_en, w_en_g;
  logic [IW-1:0] gid, gid_g;
`ifdef WRITE_BUS_ARB_STATS_EN
  logic            stats_clr = 1'b0;
  logic [N*16-1:0] gcnt, gcnt_g;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  write_bus_arbiter #(.NUM_REQ(N), .WORD_WIDTH(WW), .VALUE_WORDS(VW), .GAP_CYCLES(0)) dut (
    .clk(clk), .i_reset_n(rst_n), .i_valid(valid), .o_ready(ready),
    .i_addr(addr), .i_data(data), .o_w_addr(w_addr), .o_w_data(w_data),
    .o_w_en(w_en), .o_grant_id(gid)
`ifdef WRITE_BUS_ARB_STATS_EN
    , .i_stats_clr(stats_clr), .o_grant_count(gcnt)
`endif
  );

  write_bus_arbiter #(.NUM_REQ(N), .WORD_WIDTH(WW), .VALUE_WORDS(VW), .GAP_CYCLES(3)) dut_g (
    .clk(clk), .i_reset_n(rst_n), .i_valid(valid), .o_ready(ready_g),
    .i_addr(addr), .i_data(data), .o_w_addr(w_addr_g), .o_w_data(w_data_g),
    .o_w_en(w_en_g), .o_grant_id(gid_g)
`ifdef WRITE_BUS_ARB_STATS_EN
    , .i_stats_clr(stats_clr), .o_grant_count(gcnt_g)
`endif
  );

  task automatic do_reset();
    @(negedge clk);
    valid = '0;
    addr  = '0;
    data  = '0;
`ifdef WRITE_BUS_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = '0;
    #1;
    n_cmp++; if (ready !== 4'hF) begin n_fail++; $display("FAIL reset_ready: got %h want f", ready); end
    n_cmp++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", w_en); end
    n_cmp++; if (w_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", w_addr); end
    n_cmp++; if (w_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", w_data); end
    n_cmp++; if (gid !== 2'd0) begin n_fail++; $display("FAIL reset_gid: got %0d want 0", gid); end
    n_cmp++; if (ready_g !== 4'hF) begin n_fail++; $display("FAIL reset_ready_g: got %h want f", ready_g); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    valid = 4'b0100;
    addr[2*WW +: WW] = 8'h15;
    data[2*DW +: DW] = 32'hDEADBEEF;
    @(negedge clk);
    valid = '0;
    n_cmp++; if (ready[2] !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", ready[2]); end
    n_cmp++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b want 0", w_en); end
    @(negedge clk);
    n_cmp++; if (w_en !== 1'b1) begin n_fail++; $display("FAIL single_wen: got %b want 1", w_en); end
    n_cmp++; if (w_addr !== 8'h15) begin n_fail++; $display("FAIL single_addr: got %h want 15", w_addr); end
    n_cmp++; if (w_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h want deadbeef", w_data); end
    n_cmp++; if (gid !== 2'd2) begin n_fail++; $display("FAIL single_gid: got %0d want 2", gid); end
    n_cmp++; if (ready[2] !== 1'b1) begin n_fail++; $display("FAIL single_free: got %b want 1", ready[2]); end
    @(negedge clk);
    n_cmp++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b want 0", w_en); end
    n_cmp++; if (w_addr !== 8'h15) begin n_fail++; $display("FAIL single_hold: got %h want 15", w_addr); end
  endtask

  task automatic test_contention();
    do_reset();
    valid = '1;
    for (int k = 0; k < N; k++) begin
      addr[k*WW +: WW] = 8'(8'h40 + k);
      data[k*DW +: DW] = {8'(k), 24'hA5A5A5};
    end
    @(negedge clk);
    valid = '0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      n_cmp++; if (w_en !== 1'b1) begin n_fail++; $display("FAIL cont_wen%0d: got %b want 1", i, w_en); end
      n_cmp++; if (int'(gid) != i) begin n_fail++; $display("FAIL cont_gid%0d: got %0d want %0d", i, gid, i); end
      n_cmp++; if (w_addr !== 8'(8'h40 + i)) begin n_fail++; $display("FAIL cont_addr%0d: got %h want %h", i, w_addr, 8'(8'h40 + i)); end
    end
    @(negedge clk);
    n_cmp++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL cont_idle: got %b want 0", w_en); end
  endtask

  task automatic test_fairness();
    int cnt[N];
    int hist[$];
    int cyc;
    do_reset();
    for (int k = 0; k < N; k++) cnt[k] = 0;
    cyc = 0;
    valid = '1;
    while (hist.size() < 40 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (w_en) begin
        for (int j = 1; j <= 3 && j <= hist.size(); j++) begin
          n_cmp++;
          if (int'(gid) == hist[hist.size()-j]) begin
            n_fail++; $display("FAIL fair_repeat: got id %0d again after %0d grants, want gap of %0d", gid, j, N);
          end
        end
        hist.push_back(int'(gid));
        cnt[gid]++;
      end
    end
    valid = '0;
    n_cmp++; if (hist.size() != 40) begin n_fail++; $display("FAIL fair_timeout: got %0d grants want 40", hist.size()); end
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (cnt[k] != 10) begin n_fail++; $display("FAIL fair_count%0d: got %0d want 10", k, cnt[k]); end
    end
  endtask

  task automatic test_gap();
    int t;
    int lows;
    do_reset();
    valid = 4'b0011;
    @(negedge clk);
    valid = '0;
    t = 0;
    while (!w_en_g && t < 10) begin @(negedge clk); t++; end
    n_cmp++; if (w_en_g !== 1'b1) begin n_fail++; $display("FAIL gap_first: got %b want 1", w_en_g); end
    n_cmp++; if (gid_g !== 2'd0) begin n_fail++; $display("FAIL gap_gid0: got %0d want 0", gid_g); end
    lows = 0;
    @(negedge clk);
    while (!w_en_g && lows < 20) begin lows++; @(negedge clk); end
    n_cmp++; if (lows != 3) begin n_fail++; $display("FAIL gap_lows: got %0d want 3", lows); end
    n_cmp++; if (gid_g !== 2'd1) begin n_fail++; $display("FAIL gap_gid1: got %0d want 1", gid_g); end
  endtask

  task automatic test_backpressure();
    do_reset();
    valid = 4'b0011;
    addr[0 +: WW]  = 8'h01;  data[0 +: DW]  = 32'h0000_0001;
    addr[WW +: WW] = 8'hA1;  data[DW +: DW] = 32'hAAAA_0001;
    @(negedge clk);
    addr[WW +: WW] = 8'hB1;  data[DW +: DW] = 32'hBBBB_0001;
    valid = 4'b0010;
    n_cmp++; if (ready !== 4'b1100) begin n_fail++; $display("FAIL bp_ready: got %b want 1100", ready); end
    @(negedge clk);
    n_cmp++; if (w_en !== 1'b1 || gid !== 2'd0) begin n_fail++; $display("FAIL bp_g0: got en %b id %0d want en 1 id 0", w_en, gid); end
    n_cmp++; if (ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_full: got %b want 0", ready[1]); end
    @(negedge clk);
    n_cmp++; if (w_en !== 1'b1 || gid !== 2'd1) begin n_fail++; $display("FAIL bp_g1: got en %b id %0d want en 1 id 1", w_en, gid); end
    n_cmp++; if (w_addr !== 8'hA1) begin n_fail++; $display("FAIL bp_old_addr: got %h want a1", w_addr); end
    n_cmp++; if (w_data !== 32'hAAAA_0001) begin n_fail++; $display("FAIL bp_old_data: got %h want aaaa0001", w_data); end
    @(negedge clk);
    valid = '0;
    n_cmp++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b want 0", w_en); end
    n_cmp++; if (ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_refill: got %b want 0", ready[1]); end
    @(negedge clk);
    n_cmp++; if (w_en !== 1'b1 || gid !== 2'd1) begin n_fail++; $display("FAIL bp_g2: got en %b id %0d want en 1 id 1", w_en, gid); end
    n_cmp++; if (w_data !== 32'hBBBB_0001) begin n_fail++; $display("FAIL bp_new_data: got %h want bbbb0001", w_data); end
    // reset while slot 3 still waits and a write is on the bus
    valid = 4'b1100;
    addr[2*WW +: WW] = 8'h22; addr[3*WW +: WW] = 8'h33;
    @(negedge clk);
    valid = '0;
    @(negedge clk);
    n_cmp++; if (w_en !== 1'b1 || gid !== 2'd2) begin n_fail++; $display("FAIL rst_pre: got en %b id %0d want en 1 id 2", w_en, gid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL rst_async: got %b want 0", w_en); end
    n_cmp++; if (ready !== 4'hF) begin n_fail++; $display("FAIL rst_ready: got %h want f", ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL rst_drop%0d: got %b want 0", i, w_en); end
    end
    n_cmp++; if (ready !== 4'hF) begin n_fail++; $display("FAIL rst_after: got %h want f", ready); end
  endtask

  // Model: each edge, the first full slot after the last winner (mod N) is written;
  // empty slots take whatever their source offers on that edge.
  task automatic test_random();
    bit            mpend[N];
    logic [WW-1:0] ma[N];
    logic [DW-1:0] md[N];
    bit            acc[N];
    int            mlast, g, idx;
    logic          e_en;
    logic [WW-1:0] e_addr;
    logic [DW-1:0] e_data;
    int            e_gid;
    logic [N-1:0]  e_ready;
    do_reset();
    for (int k = 0; k < N; k++) begin mpend[k] = 0; ma[k] = '0; md[k] = '0; end
    mlast = N - 1; e_en = 1'b0; e_addr = '0; e_data = '0; e_gid = 0;
    repeat (300) begin
      valid = 4'($urandom_range(0, 15));
      addr  = $urandom;
      data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      for (int k = 0; k < N; k++) acc[k] = valid[k] && !mpend[k];
      g = -1;
      for (int i = 1; i <= N; i++) begin
        idx = (mlast + i) % N;
        if (g < 0 && mpend[idx]) g = idx;
      end
      e_en = (g >= 0);
      if (g >= 0) begin
        e_addr = ma[g]; e_data = md[g]; e_gid = g; mlast = g; mpend[g] = 0;
      end
      for (int k = 0; k < N; k++) if (acc[k]) begin
        mpend[k] = 1; ma[k] = addr[k*WW +: WW]; md[k] = data[k*DW +: DW];
      end
      for (int k = 0; k < N; k++) e_ready[k] = !mpend[k];
      @(negedge clk);
      n_cmp++; if (ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready: got %b want %b", ready, e_ready); end
      n_cmp++; if (w_en !== e_en) begin n_fail++; $display("FAIL rnd_wen: got %b want %b", w_en, e_en); end
      n_cmp++; if (w_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr: got %h want %h", w_addr, e_addr); end
      n_cmp++; if (w_data !== e_data) begin n_fail++; $display("FAIL rnd_data: got %h want %h", w_data, e_data); end
      n_cmp++; if (int'(gid) != e_gid) begin n_fail++; $display("FAIL rnd_gid: got %0d want %0d", gid, e_gid); end
    end
    valid = '0;
  endtask

`ifdef WRITE_BUS_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    repeat (5) begin
      valid = 4'b1000;
      @(negedge clk);
      valid = '0;
      repeat (3) @(negedge clk);
    end
    n_cmp++; if (gcnt[3*16 +: 16] !== 16'd5) begin n_fail++; $display("FAIL stats_five: got %0d want 5", gcnt[3*16 +: 16]); end
    n_cmp++; if (gcnt[0 +: 16] !== 16'd0) begin n_fail++; $display("FAIL stats_other: got %0d want 0", gcnt[0 +: 16]); end
    valid = 4'b1000;
    @(negedge clk);
    valid = '0;
    stats_clr = 1'b1;
    n_cmp++; if (gcnt[3*16 +: 16] !== 16'd5) begin n_fail++; $display("FAIL stats_preclr: got %0d want 5", gcnt[3*16 +: 16]); end
    @(negedge clk);
    stats_clr = 1'b0;
    n_cmp++; if (w_en !== 1'b1 || gid !== 2'd3) begin n_fail++; $display("FAIL stats_grant: got en %b id %0d want en 1 id 3", w_en, gid); end
    n_cmp++; if (gcnt[3*16 +: 16] !== 16'd0) begin n_fail++; $display("FAIL stats_clr: got %0d want 0", gcnt[3*16 +: 16]); end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_gap();
    test_backpressure();
    test_random();
`ifdef WRITE_BUS_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/write_bus_arbiter.md
Name: write_bus_arbiter

Overview:
Shares one register-file write bus (addr, data, one-cycle write-enable) between NUM_REQ independent command sources, e.g. several UART/SPI command controllers. Each source has a one-deep pending slot. A work-conserving round-robin arbiter drains the slots onto the shared bus. An optional minimum idle gap between bus writes is enforced. The block sits between the command controllers and the register bank.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WORD_WIDTH, 8, address width and data word width
VALUE_WORDS, 4, data words per write; data bus is VALUE_WORDS*WORD_WIDTH bits
GAP_CYCLES, 0, minimum idle cycles between consecutive o_w_en pulses (0..255)

Ports:
clk  in  1  clock
i_reset_n  in  1  asynchronous, active-low reset
i_valid  in  NUM_REQ  per-requester write request
o_ready  out  NUM_REQ  per-requester slot empty; accept on i_valid[k] && o_ready[k]
i_addr  in  NUM_REQ*WORD_WIDTH  flattened addresses; requester k at slice k
i_data  in  NUM_REQ*VALUE_WORDS*WORD_WIDTH  flattened data; requester k at slice k
o_w_addr  out  WORD_WIDTH  shared bus address
o_w_data  out  VALUE_WORDS*WORD_WIDTH  shared bus data
o_w_en  out  1  one-cycle write strobe
o_grant_id  out  $clog2(NUM_REQ)  requester index of the current/last write

Behaviour:
- Reset (async assert, release synchronous to clk):
  - pending = 0, o_ready = all 1s, o_w_en = 0, o_w_addr = 0, o_w_data = 0, o_grant_id = 0.
  - rr pointer (last granted) = NUM_REQ-1, so requester 0 wins first.
  - gap counter = 0.
- Capture: at a clk edge where i_valid[k] && o_ready[k], slice k of addr/data is latched into slot k and pending[k] is set. o_ready[k] = !pending[k] (registered, no combinational path from i_valid).
- Grant eligibility: grant allowed when gap counter == 0 and pending != 0.
- Grant selection: the pending slot first found scanning ptr+1, ptr+2, ... mod NUM_REQ.
- Grant edge actions:
  - o_w_addr/o_w_data load from the slot; o_w_en = 1 for exactly one cycle.
  - o_grant_id = winner; ptr = winner; pending[winner] cleared.
  - gap counter loaded with GAP_CYCLES.
- Latency: accept edge E0 -> o_w_en high during the cycle after E1 (2 edges), given no contention and gap 0.
- Slot reuse: a cleared slot shows o_ready = 1 the cycle after its grant and can be refilled at the next edge. Same-edge grant and refill of one slot is not possible.
- Gap counter: decrements by 1 per cycle while nonzero. GAP_CYCLES=0 allows a write every cycle.
- Outputs hold: o_w_addr/o_w_data/o_grant_id hold their last values when o_w_en = 0.
- Ignored requests: i_valid[k] with o_ready[k] = 0 is ignored. The source must hold the request; nothing is dropped silently inside the block.
- Fairness: with all slots continuously refilled, each requester gets exactly one write per NUM_REQ grants.
- Reset mid-operation: all pending writes are discarded and o_w_en drops immediately (async).
- Width rules: ptr and o_grant_id are $clog2(NUM_REQ) bits. Wrap-around uses an explicit compare to NUM_REQ-1, not bit overflow, for non-power-of-2 NUM_REQ.

Optional Feature:
WRITE_BUS_ARB_STATS_EN
- Defined: adds input i_stats_clr and output o_grant_count (NUM_REQ*16 bits).
  - Per-requester grant counter, saturating at 16'hFFFF, increments on each grant to that requester.
  - Synchronous clear on i_stats_clr; cleared on reset.
  - If clear and grant coincide, clear wins (counter = 0).
- Undefined: ports and counters are absent; arbitration is unaffected.

Decomposition:
- Package write_bus_pkg holds:
  - GAP_W = 8 constant;
  - STAT_W = 16 and STAT_MAX constants;
  - function rr_next(ptr, pending) for reuse by testbench models.
- Sub-module rr_pick:
  - combinational round-robin selector;
  - inputs: pending vector, ptr;
  - outputs: any, winner index.
- Slots, gap counter and output registers stay in write_bus_arbiter.

Test Plan:
1. Single write: reset, requester 2 presents addr 8'h15, data 32'hDEADBEEF for one edge -> o_ready[2] low next cycle; o_w_en one cycle at edge+2 with addr 15, data DEADBEEF, o_grant_id=2; o_ready[2] high again.
2. Contention: all 4 requesters valid on the same edge after reset -> four consecutive o_w_en cycles with grant order 0,1,2,3.
3. Fairness: all requesters continuously refill, 40 grants -> each id granted exactly 10 times, no id repeats before the other three are served.
4. Gap: GAP_CYCLES=3, requesters 0 and 1 pending -> o_w_en pulses separated by exactly 3 low cycles.
5. Backpressure and reset: slot 1 full and i_valid[1] held with new data -> new data is not captured until after the grant. Assert i_reset_n low while 2 slots are pending -> o_w_en=0 immediately, no writes issued after release, all o_ready high.
6. STATS_EN: 5 grants to requester 3, then i_stats_clr coincident with a 6th grant to requester 3 -> counter reads 5 before the clear edge and 0 after.
